// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter sharing one register-bus slave port among several bus masters.
// Grants whole transactions; an optional watchdog turns a hung access into SLAVE_ERROR.
module rggen_bus_arbiter #(
  parameter int HOSTS          = 2,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [HOSTS-1:0]                  host_request,
  input  logic [HOSTS*ADDRESS_WIDTH-1:0]    host_address,
  input  logic [HOSTS-1:0]                  host_direction,
  input  logic [HOSTS*DATA_WIDTH-1:0]       host_write_data,
  input  logic [HOSTS*DATA_WIDTH/8-1:0]     host_write_strobe,
  output logic [HOSTS-1:0]                  host_done,
  output logic [HOSTS-1:0]                  host_read_done,
  output logic [HOSTS-1:0]                  host_write_done,
  output logic [DATA_WIDTH-1:0]             host_read_data,
  output logic [1:0]                        host_status,
  output logic [HOSTS-1:0]                  grant,
  output logic                              bus_request,
  output logic [ADDRESS_WIDTH-1:0]          bus_address,
  output logic                              bus_direction,
  output logic [DATA_WIDTH-1:0]             bus_write_data,
  output logic [DATA_WIDTH/8-1:0]           bus_write_strobe,
  input  logic                              bus_done,
  input  logic [DATA_WIDTH-1:0]             bus_read_data,
  input  logic [1:0]                        bus_status
);

  localparam int StrobeWidth = DATA_WIDTH / 8;
  localparam int IndexWidth  = (HOSTS > 1) ? $clog2(HOSTS) : 1;
  localparam int CountWidth  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CountWidth-1:0] CountLast =
    (TIMEOUT_CYCLES > 0) ? CountWidth'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [IndexWidth-1:0] IndexLast = IndexWidth'(HOSTS - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StRespond} state_e;

  state_e                  state_q;
  logic [IndexWidth-1:0]   pointer_q;
  logic [IndexWidth-1:0]   index_q;
  logic [HOSTS-1:0]        grant_q;
  logic                    direction_q;
  logic [DATA_WIDTH-1:0]   read_data_q;
  logic [1:0]              status_q;
  logic [CountWidth-1:0]   count_q;

  logic [IndexWidth-1:0]   winner_index;
  logic                    winner_found;
  logic                    timeout;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    logic [IndexWidth-1:0] idx;
    winner_found = 1'b0;
    winner_index = '0;
    idx          = '0;
    for (int i = 0; i < HOSTS; i++) begin
      idx = IndexWidth'((int'(pointer_q) + i) % HOSTS);
      if (!winner_found && host_request[idx]) begin
        winner_found = 1'b1;
        winner_index = idx;
      end
    end
  end

  assign timeout = (TIMEOUT_CYCLES > 0) && (count_q == CountLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pointer_q   <= '0;
      index_q     <= '0;
      grant_q     <= '0;
      direction_q <= 1'b0;
      read_data_q <= '0;
      status_q    <= 2'b00;
      count_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (winner_found) begin
            grant_q     <= {{(HOSTS-1){1'b0}}, 1'b1} << winner_index;
            index_q     <= winner_index;
            direction_q <= host_direction[winner_index];
            count_q     <= '0;
            state_q     <= StBusy;
          end
        end
        StBusy: begin
          // A downstream completion in the same cycle takes priority over the watchdog.
          if (bus_done) begin
            read_data_q <= bus_read_data;
            status_q    <= bus_status;
            state_q     <= StRespond;
          end else if (timeout) begin
            read_data_q <= '0;
            status_q    <= 2'b10;
            state_q     <= StRespond;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        StRespond: begin
          pointer_q <= (index_q == IndexLast) ? '0 : index_q + 1'b1;
          grant_q   <= '0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant       = grant_q;
  assign bus_request = (state_q == StBusy);

  always_comb begin
    bus_address      = '0;
    bus_direction    = 1'b0;
    bus_write_data   = '0;
    bus_write_strobe = '0;
    if (state_q == StBusy) begin
      bus_address      = host_address[index_q*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      bus_direction    = host_direction[index_q];
      bus_write_data   = host_write_data[index_q*DATA_WIDTH +: DATA_WIDTH];
      bus_write_strobe = host_write_strobe[index_q*StrobeWidth +: StrobeWidth];
    end
  end

  always_comb begin
    host_done       = '0;
    host_read_data  = '0;
    host_status     = 2'b00;
    if (state_q == StRespond) begin
      host_done      = grant_q;
      host_read_data = read_data_q;
      host_status    = status_q;
    end
    host_read_done  = direction_q ? '0 : host_done;
    host_write_done = direction_q ? host_done : '0;
  end

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Scoreboard bench for rggen_bus_arbiter: directed accesses push expected bus and host
// responses; a monitor pops and compares whenever the DUT presents them.
module tb_rggen_bus_arbiter;

  localparam int H  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [H-1:0]    host_request;
  logic [H*AW-1:0] host_address;
  logic [H-1:0]    host_direction;
  logic [H*DW-1:0] host_write_data;
  logic [H*SW-1:0] host_write_strobe;
  logic [H-1:0]    host_done;
  logic [H-1:0]    host_read_done;
  logic [H-1:0]    host_write_done;
  logic [DW-1:0]   host_read_data;
  logic [1:0]      host_status;
  logic [H-1:0]    grant;
  logic            bus_request;
  logic [AW-1:0]   bus_address;
  logic            bus_direction;
  logic [DW-1:0]   bus_write_data;
  logic [SW-1:0]   bus_write_strobe;
  logic            bus_done;
  logic [DW-1:0]   bus_read_data;
  logic [1:0]      bus_status;

  rggen_bus_arbiter #(
    .HOSTS          (H),
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .host_request      (host_request),
    .host_address      (host_address),
    .host_direction    (host_direction),
    .host_write_data   (host_write_data),
    .host_write_strobe (host_write_strobe),
    .host_done         (host_done),
    .host_read_done    (host_read_done),
    .host_write_done   (host_write_done),
    .host_read_data    (host_read_data),
    .host_status       (host_status),
    .grant             (grant),
    .bus_request       (bus_request),
    .bus_address       (bus_address),
    .bus_direction     (bus_direction),
    .bus_write_data    (bus_write_data),
    .bus_write_strobe  (bus_write_strobe),
    .bus_done          (bus_done),
    .bus_read_data     (bus_read_data),
    .bus_status        (bus_status)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [H-1:0]  grant;
    logic [AW-1:0] addr;
    logic          dir;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } bus_exp_t;

  typedef struct packed {
    logic [H-1:0]  done;
    logic [H-1:0]  rdone;
    logic [H-1:0]  wdone;
    logic [DW-1:0] data;
    logic [1:0]    status;
  } host_exp_t;

  bus_exp_t  bus_q[$];
  host_exp_t host_q[$];
  int        checks = 0;
  int        errors = 0;
  logic      mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_host(input int i, input logic dir, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
    host_direction[i]             = dir;
    host_address[i*AW +: AW]      = a;
    host_write_data[i*DW +: DW]   = d;
    host_write_strobe[i*SW +: SW] = s;
  endtask

  task automatic expect_bus(input logic [H-1:0] g, input logic [AW-1:0] a, input logic dir,
                            input logic [DW-1:0] d, input logic [SW-1:0] s);
    bus_exp_t e;
    e.grant = g; e.addr = a; e.dir = dir; e.wdata = d; e.strb = s;
    bus_q.push_back(e);
  endtask

  task automatic expect_host(input logic [H-1:0] g, input logic dir, input logic [DW-1:0] d,
                             input logic [1:0] st);
    host_exp_t e;
    e.done = g; e.rdone = dir ? '0 : g; e.wdone = dir ? g : '0; e.data = d; e.status = st;
    host_q.push_back(e);
  endtask

  task automatic wait_bus(output int n);
    n = 0;
    while (!bus_request && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus_request) chk("bus_request_wait", {63'd0, bus_request}, 64'd1);
  endtask

  // Downstream completion pulse, driven mid-cycle for one cycle.
  task automatic respond(input logic [DW-1:0] d, input logic [1:0] st);
    bus_read_data = d;
    bus_status    = st;
    bus_done      = 1'b1;
    @(negedge clk);
    bus_done      = 1'b0;
    bus_read_data = '0;
    bus_status    = 2'b00;
  endtask

  task automatic serve(input int lat, input logic [DW-1:0] d, input logic [1:0] st);
    int n;
    wait_bus(n);
    repeat (lat) @(negedge clk);
    respond(d, st);
  endtask

  // Monitor: compares against the scoreboard queues whenever the DUT presents traffic.
  initial begin
    logic prev_req;
    bus_exp_t be;
    host_exp_t he;
    prev_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (bus_request && !prev_req) begin
          if (bus_q.size() == 0) begin
            chk("unexpected_bus_request", {63'd0, bus_request}, 64'd0);
          end else begin
            be = bus_q.pop_front();
            chk("bus_grant", grant, be.grant);
            chk("bus_address", bus_address, be.addr);
            chk("bus_direction", bus_direction, be.dir);
            chk("bus_write_data", bus_write_data, be.wdata);
            chk("bus_write_strobe", bus_write_strobe, be.strb);
          end
        end
        if (!bus_request)
          chk("bus_idle_zero", {bus_address, bus_direction, bus_write_data, bus_write_strobe}, 0);
        if (host_done != '0) begin
          if (host_q.size() == 0) begin
            chk("unexpected_host_done", host_done, 0);
          end else begin
            he = host_q.pop_front();
            chk("host_done", host_done, he.done);
            chk("host_read_done", host_read_done, he.rdone);
            chk("host_write_done", host_write_done, he.wdone);
            chk("host_read_data", host_read_data, he.data);
            chk("host_status", host_status, he.status);
            chk("respond_grant", grant, he.done);
          end
        end else begin
          chk("idle_response_zero",
              {host_read_data, host_status, host_read_done, host_write_done}, 0);
        end
        prev_req = bus_request;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [AW-1:0] rr_addr[3];
    logic [DW-1:0] rr_data[3];
    logic [SW-1:0] rr_strb[3];
    logic          rr_dir[3];
    int n, cnt;
    rr_addr = '{16'h0100, 16'h0104, 16'h0108};
    rr_data = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};
    rr_strb = '{4'hF, 4'h1, 4'hC};
    rr_dir  = '{1'b1, 1'b0, 1'b1};

    rst = 1'b1; host_request = '0; host_address = '0; host_direction = '0;
    host_write_data = '0; host_write_strobe = '0;
    bus_done = 1'b0; bus_read_data = '0; bus_status = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_grant", grant, 0);
    chk("reset_bus_request", {63'd0, bus_request}, 0);
    chk("reset_host_done", {host_done, host_read_done, host_write_done}, 0);
    chk("reset_response", {host_read_data, host_status}, 0);
    chk("reset_bus_fields", {bus_address, bus_direction, bus_write_data, bus_write_strobe}, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Single write from host0, downstream done two cycles after bus_request.
    set_host(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
    set_host(1, 1'b0, 16'h0004, 32'h11112222, 4'h3);
    set_host(2, 1'b1, 16'h0008, 32'h33334444, 4'h8);
    expect_bus(3'b001, 16'h0010, 1'b1, 32'hDEADBEEF, 4'hF);
    expect_host(3'b001, 1'b1, 32'hA5A50000, 2'b00);
    host_request = 3'b001;
    wait_bus(n);
    chk("request_to_bus_latency", n, 1);
    repeat (2) @(negedge clk);
    respond(32'hA5A50000, 2'b00);
    host_request = '0;
    @(negedge clk);

    // Read return to host1, downstream done in the first BUSY cycle.
    expect_bus(3'b010, 16'h0004, 1'b0, 32'h11112222, 4'h3);
    expect_host(3'b010, 1'b0, 32'h12345678, 2'b00);
    host_request = 3'b010;
    serve(0, 32'h12345678, 2'b00);
    host_request = '0;
    @(negedge clk);

    // Round-robin from reset with all three hosts requesting continuously.
    rst = 1'b1;
    for (int i = 0; i < H; i++) set_host(i, rr_dir[i], rr_addr[i], rr_data[i], rr_strb[i]);
    host_request = 3'b111;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_bus(3'b001 << (k % 3), rr_addr[k % 3], rr_dir[k % 3], rr_data[k % 3],
                 rr_strb[k % 3]);
      expect_host(3'b001 << (k % 3), rr_dir[k % 3], 32'hC0DE0000 + k,
                  (k == 2) ? 2'b10 : 2'b00);
    end
    for (int k = 0; k < 4; k++) begin
      serve(k, 32'hC0DE0000 + k, (k == 2) ? 2'b10 : 2'b00);
      if (k == 3) host_request = '0;
    end
    @(negedge clk);

    // Host2 finishes while host0 and host2 both request: host0 next, then host2 again.
    expect_bus(3'b100, rr_addr[2], rr_dir[2], rr_data[2], rr_strb[2]);
    expect_bus(3'b001, rr_addr[0], rr_dir[0], rr_data[0], rr_strb[0]);
    expect_bus(3'b100, rr_addr[2], rr_dir[2], rr_data[2], rr_strb[2]);
    expect_host(3'b100, 1'b1, 32'hD0000001, 2'b00);
    expect_host(3'b001, 1'b1, 32'hD0000002, 2'b00);
    expect_host(3'b100, 1'b1, 32'hD0000003, 2'b00);
    host_request = 3'b100;
    wait_bus(n);
    host_request[0] = 1'b1;
    @(negedge clk);
    respond(32'hD0000001, 2'b00);
    serve(1, 32'hD0000002, 2'b00);
    serve(2, 32'hD0000003, 2'b00);
    host_request = '0;
    @(negedge clk);

    // Watchdog: no downstream response, then a stale done after RESPOND.
    set_host(0, 1'b0, 16'h0020, 32'h0, 4'h0);
    expect_bus(3'b001, 16'h0020, 1'b0, 32'h0, 4'h0);
    expect_host(3'b001, 1'b0, 32'h0, 2'b10);
    host_request = 3'b001;
    wait_bus(n);
    cnt = 0;
    while (!host_done[0] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_latency", cnt, TO);
    host_request = '0;
    repeat (2) @(negedge clk);
    respond(32'h99999999, 2'b00);
    chk("late_done_grant", grant, 0);
    chk("late_done_bus_request", {63'd0, bus_request}, 0);
    repeat (2) @(negedge clk);

    // bus_done on the same cycle the watchdog would fire: OKAY response wins.
    set_host(1, 1'b0, 16'h0030, 32'h0, 4'h0);
    expect_bus(3'b010, 16'h0030, 1'b0, 32'h0, 4'h0);
    expect_host(3'b010, 1'b0, 32'hFACECAFE, 2'b00);
    host_request = 3'b010;
    wait_bus(n);
    repeat (TO - 1) @(negedge clk);
    respond(32'hFACECAFE, 2'b00);
    chk("simultaneous_done", host_done, 3'b010);
    host_request = '0;
    @(negedge clk);

    // Reset mid-BUSY aborts the access and clears the pointer.
    set_host(0, 1'b1, 16'h0040, 32'h01020304, 4'h5);
    expect_bus(3'b001, 16'h0040, 1'b1, 32'h01020304, 4'h5);
    host_request = 3'b001;
    wait_bus(n);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    host_request = '0;
    chk("reset_abort_grant", grant, 0);
    chk("reset_abort_bus_request", {63'd0, bus_request}, 0);
    chk("reset_abort_host_done", host_done, 0);
    @(negedge clk);
    set_host(1, 1'b0, 16'h0044, 32'h0, 4'h0);
    set_host(2, 1'b1, 16'h0048, 32'h55667788, 4'hF);
    expect_bus(3'b010, 16'h0044, 1'b0, 32'h0, 4'h0);
    expect_host(3'b010, 1'b0, 32'h87654321, 2'b00);
    host_request = 3'b110;
    serve(2, 32'h87654321, 2'b00);
    host_request = '0;
    repeat (3) @(negedge clk);

    chk("bus_queue_drained", bus_q.size(), 0);
    chk("host_queue_drained", host_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rggen_bus_arbiter.md
Name: rggen_bus_arbiter

Overview:
- Shares one register-bus slave port (the bus splitter's input) among HOSTS independent bus masters, e.g. CPU bridge plus debug port.
- Round-robin arbitration at transaction granularity: a granted host keeps the bus until its access completes or times out.
- Captures the downstream response and returns it to the granted host as a one-cycle registered done pulse.
- A watchdog converts a hung downstream access into a SLAVE_ERROR response.

Parameters:
- HOSTS, 2: number of requesting masters, 2 or more.
- ADDRESS_WIDTH, 16: byte address width.
- DATA_WIDTH, 32: data width, a multiple of 8.
- TIMEOUT_CYCLES, 0: watchdog limit in BUSY cycles; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- host_request  in  HOSTS  per-host access request, held until that host's done
- host_address  in  HOSTS*ADDRESS_WIDTH  per-host address; host i occupies slice [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- host_direction  in  HOSTS  per-host direction, 0=read, 1=write
- host_write_data  in  HOSTS*DATA_WIDTH  per-host write data
- host_write_strobe  in  HOSTS*DATA_WIDTH/8  per-host byte strobes
- host_done  out  HOSTS  one-hot completion pulse
- host_read_done  out  HOSTS  done qualified by read
- host_write_done  out  HOSTS  done qualified by write
- host_read_data  out  DATA_WIDTH  response data, broadcast to all hosts, valid with done
- host_status  out  2  response status, broadcast; 2'b00=OKAY, 2'b10=SLAVE_ERROR
- grant  out  HOSTS  one-hot current owner, 0 when idle
- bus_request  out  1  downstream request
- bus_address  out  ADDRESS_WIDTH  downstream address
- bus_direction  out  1  downstream direction
- bus_write_data  out  DATA_WIDTH  downstream write data
- bus_write_strobe  out  DATA_WIDTH/8  downstream strobes
- bus_done  in  1  downstream completion pulse
- bus_read_data  in  DATA_WIDTH  downstream read data
- bus_status  in  2  downstream status

Behaviour:
- Reset state:
  - State=IDLE and round-robin pointer=0.
  - All outputs 0, including grant and host_status=OKAY.
  - Reset asserted mid-transaction aborts it: no done is issued, and bus_request drops on the next cycle.
- FSM states: IDLE, BUSY, RESPOND.
- IDLE:
  - If any host_request is set, select the first requesting host at or after the pointer, wrapping modulo HOSTS.
  - Register the winner into grant; go to BUSY.
  - With no requests, stay in IDLE.
- BUSY:
  - bus_request=1.
  - bus_address, bus_direction, bus_write_data and bus_write_strobe are muxed from the granted host's slices; they are combinational from grant.
  - Outside BUSY, bus_request=0 and the other bus_* outputs are 0.
  - On bus_done: capture bus_read_data and bus_status (read_data captured as-is even for writes); go to RESPOND.
  - A host that drops host_request during BUSY is a protocol violation; it is ignored and the transaction continues.
- Watchdog:
  - Runs when TIMEOUT_CYCLES>0. A counter clears on BUSY entry and increments each BUSY cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 with no bus_done, capture read_data=0 and status=SLAVE_ERROR; go to RESPOND.
  - bus_done in the same cycle wins over the timeout.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- RESPOND (exactly one cycle):
  - host_done[g]=1; host_read_done[g] or host_write_done[g] set according to the latched direction.
  - host_read_data and host_status driven from the capture registers; outside RESPOND both are 0.
  - Pointer = g+1 mod HOSTS; grant clears; return to IDLE.
  - bus_request is low here, so the downstream slave sees request fall the cycle after its done and never double-completes.
- Ignore rules: bus_done in IDLE or RESPOND (stale, post-timeout) is ignored. The arbiter is never in BUSY after RESPOND without first passing through IDLE.
- Latency: request asserted in cycle T, bus_request in T+1; downstream done in cycle M gives host done in M+1.
- Back-to-back throughput: 1 IDLE + k BUSY + 1 RESPOND cycles per access, where k is the downstream latency.
- Host rule: deassert host_request the cycle after observing host_done. A request held high is treated as a new access.

Test Plan:
- Single write: host0 writes addr 0x0010, data 0xDEADBEEF, strobe 4'hF; downstream done with OKAY two cycles after bus_request → bus_* matches host0 slices; host_done[0] and host_write_done[0] pulse for exactly one cycle; host_status=00.
- Read return: host1 reads 0x0004; downstream returns 0x12345678 OKAY → host_read_done[1]=1, host_read_data=0x12345678, host_done[0]=0.
- Round-robin: HOSTS=3, all three requesting continuously from reset → grant sequence 001,010,100,001.
- Round-robin, repeat requester: host2 finishes while host0 and host2 both request → next grant is host0.
- Timeout: TIMEOUT_CYCLES=8, downstream never responds → RESPOND exactly 8 BUSY cycles after grant, status=10, read_data=0. A late bus_done two cycles later produces no host_done.
- Simultaneous: bus_done in the same cycle the counter hits 7 → the OKAY response is returned with the downstream data.
- Reset mid-BUSY: assert rst for one cycle → grant=0, bus_request=0 next cycle, no host_done, pointer=0; a fresh host1 request is then served normally.
